// File: rtl/seq_nibble_adder_ctrl.sv
// rtl/seq_nibble_adder_ctrl.sv - sequential nibble-serial adder with valid/ready handshakes
//
// Purpose:
//   Adds two WIDTH-bit operands plus a carry-in using one 4-bit slice built
//   from four full_adder cells, one nibble per cycle, LSB nibble first.
//   A carry register links consecutive nibbles.
//
// Configuration macro:
//   SEQ_ADD_APPROX_LSB_EN - when defined, the carry out of nibble 0 is dropped
//   (carry into nibble 1 forced to 0). Timing and handshake are unchanged.
//   Undefined (default): exact carry chain.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      synchronous active-low reset
//   in_valid   in   1      operand pair valid
//   in_ready   out  1      accepting operands (IDLE only)
//   a, b       in   WIDTH  operands, sampled on accept
//   cin        in   1      carry into nibble 0, sampled on accept
//   out_valid  out  1      sum/cout valid (DONE only)
//   out_ready  in   1      sink accepts result
//   sum        out  WIDTH  result
//   cout       out  1      carry out of the top nibble
//   busy       out  1      high in RUN or DONE

module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module seq_nibble_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

`ifdef SEQ_ADD_APPROX_LSB_EN
  localparam bit APPROX = 1'b1;
`else
  localparam bit APPROX = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;

  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_sum;
  logic              r_cout;
  logic              r_carry;
  logic [IDXW-1:0]   r_idx;

  logic [IDXW+1:0]   w_shamt;
  logic [3:0]        w_a_nib;
  logic [3:0]        w_b_nib;
  logic [3:0]        w_s_nib;
  logic [4:0]        w_c;
  logic              w_last;
  logic              w_carry_next;
  logic [WIDTH-1:0]  w_nib_mask;
  logic [WIDTH-1:0]  w_nib_val;

  // Bit offset of the current nibble (idx * 4).
  assign w_shamt = {r_idx, 2'b00};
  assign w_a_nib = 4'(r_a >> w_shamt);
  assign w_b_nib = 4'(r_b >> w_shamt);

  // The single shared 4-bit ripple slice.
  assign w_c[0] = r_carry;
  for (genvar g = 0; g < 4; g++) begin : g_slice
    full_adder u_fa (
      .i_a (w_a_nib[g]),
      .i_b (w_b_nib[g]),
      .i_c (w_c[g]),
      .o_s (w_s_nib[g]),
      .o_c (w_c[g+1])
    );
  end

  assign w_last     = (r_idx == IDXW'(NIB - 1));
  // Approximate mode drops only the link from nibble 0 to nibble 1; the
  // final cout always comes straight from the slice.
  assign w_carry_next = (APPROX && (r_idx == '0)) ? 1'b0 : w_c[4];
  assign w_nib_mask = WIDTH'(4'hF) << w_shamt;
  assign w_nib_val  = WIDTH'(w_s_nib) << w_shamt;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_next_state = S_RUN;
      S_RUN:   if (w_last)    w_next_state = S_DONE;
      S_DONE:  if (out_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
    busy      = (r_state != S_IDLE);
    sum       = r_sum;
    cout      = r_cout;
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_carry <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_idx   <= '0;
            r_sum   <= '0;
          end
        end
        S_RUN: begin
          r_sum   <= (r_sum & ~w_nib_mask) | w_nib_val;
          r_carry <= w_carry_next;
          if (w_last) begin
            r_cout <= w_c[4];
          end else begin
            r_idx  <= r_idx + IDXW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_nibble_adder_ctrl.sv
// tb/tb_seq_nibble_adder_ctrl.sv - self-checking bench for seq_nibble_adder_ctrl

module tb_seq_nibble_adder_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
  logic [15:0] a, b, sum;

  logic        in_valid4, in_ready4, cin4, out_valid4, out_ready4, cout4, busy4;
  logic [3:0]  a4, b4, sum4;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_nibble_adder_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  seq_nibble_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .cout(cout4), .busy(busy4)
  );

  // Reference: whole-word arithmetic; approximate mode adds the low nibble
  // and the upper bits separately so no carry crosses bit 4.
  function automatic logic [16:0] ref16(input logic [15:0] x, input logic [15:0] y, input logic c);
`ifdef SEQ_ADD_APPROX_LSB_EN
    logic [4:0]  lo;
    logic [12:0] hi;
    lo = {1'b0, x[3:0]} + {1'b0, y[3:0]} + {4'd0, c};
    hi = {1'b0, x[15:4]} + {1'b0, y[15:4]};
    return {hi, lo[3:0]};
`else
    return {1'b0, x} + {1'b0, y} + {16'd0, c};
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full 16-bit transaction; hold = cycles out_ready stays low in DONE.
  task automatic run16(input logic [15:0] xa, input logic [15:0] xb, input logic xc, input int hold);
    logic [16:0] r;
    int lat;
    r = ref16(xa, xb, xc);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1; a = xa; b = xb; cin = xc;
    step();
    in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      chk("run_in_ready", 32'(in_ready), 32'd0);
      chk("run_busy", 32'(busy), 32'd1);
      step();
      lat++;
    end
    chk("latency", 32'(lat), 32'd4);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom); a = 16'($urandom); b = 16'($urandom);
      step();
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_sum", 32'(sum), 32'(r[15:0]));
      chk("hold_cout", 32'(cout), 32'(r[16]));
    end
    in_valid = 1'b0;
    chk("sum", 32'(sum), 32'(r[15:0]));
    chk("cout", 32'(cout), 32'(r[16]));
    chk("done_busy", 32'(busy), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("post_valid", 32'(out_valid), 32'd0);
    chk("post_in_ready", 32'(in_ready), 32'd1);
    chk("post_sum_held", 32'(sum), 32'(r[15:0]));
  endtask

  task automatic run4(input logic [3:0] xa, input logic [3:0] xb, input logic xc);
    logic [4:0] r;
    int lat;
    r = {1'b0, xa} + {1'b0, xb} + {4'd0, xc};
    in_valid4 = 1'b1; a4 = xa; b4 = xb; cin4 = xc;
    step();
    in_valid4 = 1'b0;
    lat = 0;
    while (!out_valid4 && lat < 10) begin
      step();
      lat++;
    end
    chk("w4_latency", 32'(lat), 32'd1);
    chk("w4_sum", 32'(sum4), 32'(r[3:0]));
    chk("w4_cout", 32'(cout4), 32'(r[4]));
    out_ready4 = 1'b1;
    step();
    out_ready4 = 1'b0;
    chk("w4_post_ready", 32'(in_ready4), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    step(); step();
    rst_n = 1'b1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);

    // T1, T2, T3
    run16(16'hFFFF, 16'h0001, 1'b0, 0);
    run16(16'h1234, 16'h4321, 1'b1, 0);
    run16(16'h000F, 16'h0001, 1'b0, 0);
    // T4: back-pressure in DONE with ignored in_valid pulses
    run16(16'hA5A5, 16'h5A5B, 1'b1, 3);
    run16(16'hFFFF, 16'hFFFF, 1'b1, 1);

    // T5: reset at idx=2 of RUN
    in_valid = 1'b1; a = 16'hBEEF; b = 16'h1111; cin = 1'b0;
    step();
    in_valid = 1'b0;
    step(); step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    run16(16'h0F0F, 16'hF0F1, 1'b0, 0);

    // Randomized traffic
    for (int k = 0; k < 25; k++) begin
      run16(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    end

    // T6 plus random 4-bit ops
    run4(4'h9, 4'h8, 1'b0);
    run4(4'hF, 4'hF, 1'b1);
    for (int k = 0; k < 10; k++) begin
      run4(4'($urandom), 4'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
